// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle for the SDRAM port arbiter: loader write side, player read
// side and the shared controller port.
interface sdram_port_arbiter_if #(
  parameter int AW = 25,
  parameter int DW = 8
);
  logic          wr_stb;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_busy;
  logic          wr_ovf;
  logic [AW-1:0] wr_count;
  logic          cnt_clr;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic          mem_rd;
  logic [DW-1:0] mem_dout;
  logic          mem_ready;
  logic          mem_tmo;

  // Arbiter side
  modport slave (
    input  wr_stb, wr_addr, wr_data, cnt_clr, rd_req, rd_addr, mem_dout, mem_ready,
    output wr_busy, wr_ovf, wr_count, rd_ack, rd_data, mem_addr, mem_din, mem_we,
           mem_rd, mem_tmo
  );

  // Requesters + controller side
  modport master (
    output wr_stb, wr_addr, wr_data, cnt_clr, rd_req, rd_addr, mem_dout, mem_ready,
    input  wr_busy, wr_ovf, wr_count, rd_ack, rd_data, mem_addr, mem_din, mem_we,
           mem_rd, mem_tmo
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-requester arbiter for one 8-bit SDRAM controller port.
// Loader writes go through a one-deep holding register; player reads are
// level request / pulse ack. One command in flight at a time, fair tiebreak,
// stall timeout, sticky overflow/timeout flags and a completed-write counter.
module sdram_port_arbiter #(
  parameter int AW         = 25,
  parameter int DW         = 8,
  parameter int TMO_CYCLES = 255
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  sdram_port_arbiter_if.slave  bus
);
  localparam int TW = $clog2(TMO_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          hold_full_q, hold_full_d;
  logic [AW-1:0] hold_addr_q, hold_addr_d;
  logic [DW-1:0] hold_data_q, hold_data_d;
  logic          last_rd_q, last_rd_d;    // 1: last grant was the read side
  logic          grant_rd_q, grant_rd_d;  // 1: command in flight is a read
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic          seen_busy_q, seen_busy_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          wr_ovf_q, wr_ovf_d;
  logic [AW-1:0] wr_count_q, wr_count_d;
  logic          mem_tmo_q, mem_tmo_d;

  logic issue, issue_wr;

  // Command goes out the cycle ISSUE sees the controller ready.
  assign issue    = (state_q == S_ISSUE) && bus.mem_ready;
  assign issue_wr = issue && !grant_rd_q;

  // Next-state, holding register, grant and completion bookkeeping.
  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    last_rd_d   = last_rd_q;
    grant_rd_d  = grant_rd_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    seen_busy_d = seen_busy_q;
    tmo_cnt_d   = tmo_cnt_q;
    rd_data_d   = rd_data_q;
    wr_ovf_d    = wr_ovf_q;
    wr_count_d  = wr_count_q;
    mem_tmo_d   = mem_tmo_q;

    // Holding register frees up as its write issues, so a strobe in that
    // same cycle refills it instead of overflowing.
    if (issue_wr) hold_full_d = 1'b0;
    if (bus.wr_stb) begin
      if (!hold_full_q || issue_wr) begin
        hold_full_d = 1'b1;
        hold_addr_d = bus.wr_addr;
        hold_data_d = bus.wr_data;
      end else begin
        wr_ovf_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (hold_full_q || bus.rd_req) begin
          // On a tie, the side that did not win last time goes first.
          grant_rd_d = bus.rd_req && (!hold_full_q || !last_rd_q);
          last_rd_d  = grant_rd_d;
          if (grant_rd_d) begin
            mem_addr_d = bus.rd_addr;
          end else begin
            mem_addr_d = hold_addr_q;
            mem_din_d  = hold_data_q;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Waiting for ready here is not a stall of our command yet.
        if (bus.mem_ready) begin
          seen_busy_d = 1'b0;
          tmo_cnt_d   = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // Completion needs a busy phase first; ready right after the
        // command is the controller still reporting the previous idle.
        if (!bus.mem_ready) seen_busy_d = 1'b1;
        if (bus.mem_ready && seen_busy_q) begin
          state_d = S_DONE;
          if (grant_rd_q) rd_data_d = bus.mem_dout;
          else            wr_count_d = wr_count_q + 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (tmo_cnt_d == TW'(TMO_CYCLES)) begin
            mem_tmo_d = 1'b1;
            state_d   = S_DONE;
            if (grant_rd_q) rd_data_d = '1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Clear wins over a same-cycle increment or flag set.
    if (bus.cnt_clr) begin
      wr_count_d = '0;
      wr_ovf_d   = 1'b0;
      mem_tmo_d  = 1'b0;
    end
  end

  // State register; reset abandons any command in flight.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hold_full_q <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      last_rd_q   <= 1'b1;
      grant_rd_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      seen_busy_q <= 1'b0;
      tmo_cnt_q   <= '0;
      rd_data_q   <= '0;
      wr_ovf_q    <= 1'b0;
      wr_count_q  <= '0;
      mem_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      last_rd_q   <= last_rd_d;
      grant_rd_q  <= grant_rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      seen_busy_q <= seen_busy_d;
      tmo_cnt_q   <= tmo_cnt_d;
      rd_data_q   <= rd_data_d;
      wr_ovf_q    <= wr_ovf_d;
      wr_count_q  <= wr_count_d;
      mem_tmo_q   <= mem_tmo_d;
    end
  end

  assign bus.wr_busy  = hold_full_q;
  assign bus.wr_ovf   = wr_ovf_q;
  assign bus.wr_count = wr_count_q;
  assign bus.rd_ack   = (state_q == S_DONE) && grant_rd_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.mem_we   = issue_wr;
  assign bus.mem_rd   = issue && grant_rd_q;
  assign bus.mem_tmo  = mem_tmo_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: vector table of single
// transactions plus hand sequences for contention, overflow, timeout,
// reset mid-command and clear-vs-increment.
module tb_sdram_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.AW(25), .DW(8)) bus ();
  sdram_port_arbiter #(.AW(25), .DW(8), .TMO_CYCLES(255)) dut (
    .clk_sys(clk), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Controller model: ready drops the cycle after a command, low 3 cycles.
  bit stuck = 1'b0;
  int bcnt;
  always @(posedge clk) begin
    if (reset) begin
      bus.mem_ready <= 1'b1;
      bcnt <= 0;
    end else if (bus.mem_we || bus.mem_rd) begin
      bus.mem_ready <= 1'b0;
      bcnt <= 3;
    end else if (bcnt > 0) begin
      bcnt <= bcnt - 1;
      bus.mem_ready <= (bcnt == 1) && !stuck;
    end else begin
      bus.mem_ready <= !stuck;
    end
  end

  // Monitor of commands and acks, mid-cycle.
  int we_cnt = 0, rd_cnt = 0, ack_cnt = 0, both_cnt = 0;
  logic [24:0] we_addr, rd_addr_seen;
  logic [7:0]  we_din, ack_data;
  int ord_q[$];
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_we) begin we_cnt++; we_addr = bus.mem_addr; we_din = bus.mem_din; ord_q.push_back(0); end
      if (bus.mem_rd) begin rd_cnt++; rd_addr_seen = bus.mem_addr; ord_q.push_back(1); end
      if (bus.rd_ack) begin ack_cnt++; ack_data = bus.rd_data; end
      if (bus.mem_we && bus.mem_rd) both_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_write(input logic [24:0] a, input logic [7:0] d);
    bus.wr_addr = a; bus.wr_data = d; bus.wr_stb = 1'b1;
    tick();
    bus.wr_stb = 1'b0;
  endtask

  task automatic wait_we(input string nm);
    for (int i = 0; i < 50 && !bus.mem_we; i++) tick();
    chk(nm, bus.mem_we, 1);
  endtask

  // Raise rd_req, wait for the ack, drop rd_req in the ack cycle.
  // lat = cycles from mem_rd to rd_ack; stick freezes ready low after mem_rd.
  task automatic do_read(input logic [24:0] a, input logic [7:0] dout, input int budget,
                         input bit stick, output int lat);
    int t0 = 0;
    bit got = 1'b0;
    lat = -1;
    bus.rd_addr = a; bus.mem_dout = dout; bus.rd_req = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.mem_rd) begin t0 = i; if (stick) stuck = 1'b1; end
      if (bus.rd_ack) begin lat = i - t0; got = 1'b1; break; end
    end
    bus.rd_req = 1'b0;
    if (!got) chk("rd_ack_timeout", 0, 1);
  endtask

  task automatic pulse_clr();
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
  endtask

  typedef struct {
    bit          is_rd;
    logic [24:0] addr;
    logic [7:0]  data;     // write data, or controller read data
    logic [24:0] exp_cnt;
    logic [7:0]  exp_rd;
  } vec_t;
  vec_t vecs[6];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int we0, rd0, ack0, ob, lat;
    vecs[0] = '{0, 25'h0000010, 8'hA5, 25'd1, 8'h00};
    vecs[1] = '{1, 25'h0000020, 8'h3C, 25'd1, 8'h3C};
    vecs[2] = '{0, 25'h1FFFFFF, 8'h00, 25'd2, 8'h3C};
    vecs[3] = '{1, 25'h0000000, 8'hFF, 25'd2, 8'hFF};
    vecs[4] = '{0, 25'h0ABCDEF, 8'h5A, 25'd3, 8'hFF};
    vecs[5] = '{1, 25'h1234567, 8'h81, 25'd3, 8'h81};

    bus.wr_stb = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.cnt_clr = 0;
    bus.rd_req = 0; bus.rd_addr = 0; bus.mem_dout = 0;
    reset = 1'b1;
    settle(3);
    chk("rst_count", bus.wr_count, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_misc", {bus.wr_busy, bus.wr_ovf, bus.rd_ack, bus.rd_data, bus.mem_din,
                     bus.mem_we, bus.mem_rd, bus.mem_tmo}, 0);
    reset = 1'b0;
    settle(2);

    // Vector table: one isolated transaction each.
    for (int i = 0; i < 6; i++) begin
      we0 = we_cnt; rd0 = rd_cnt; ack0 = ack_cnt;
      if (!vecs[i].is_rd) begin
        do_write(vecs[i].addr, vecs[i].data);
        settle(12);
        chk($sformatf("v%0d_we_n", i), we_cnt - we0, 1);
        chk($sformatf("v%0d_we_addr", i), we_addr, vecs[i].addr);
        chk($sformatf("v%0d_we_din", i), we_din, vecs[i].data);
        chk($sformatf("v%0d_addr_hold", i), bus.mem_addr, vecs[i].addr);
        chk($sformatf("v%0d_busy", i), bus.wr_busy, 0);
      end else begin
        do_read(vecs[i].addr, vecs[i].data, 50, 0, lat);
        chk($sformatf("v%0d_ack_data", i), ack_data, vecs[i].exp_rd);
        settle(4);
        chk($sformatf("v%0d_rd_n", i), rd_cnt - rd0, 1);
        chk($sformatf("v%0d_ack_n", i), ack_cnt - ack0, 1);
        chk($sformatf("v%0d_rd_addr", i), rd_addr_seen, vecs[i].addr);
        chk($sformatf("v%0d_rd_hold", i), bus.rd_data, vecs[i].exp_rd);
      end
      chk($sformatf("v%0d_count", i), bus.wr_count, vecs[i].exp_cnt);
    end

    // wr_busy falls right after the issuing cycle.
    do_write(25'h100, 8'h11);
    wait_we("busy_we");
    chk("busy_at_issue", bus.wr_busy, 1);
    tick();
    chk("busy_after_issue", bus.wr_busy, 0);
    settle(10);

    // Contention from reset: write wins the first tie.
    reset = 1'b1; settle(2); reset = 1'b0; settle(1);
    ob = ord_q.size();
    do_write(25'h200, 8'h22);
    do_read(25'h300, 8'h33, 60, 0, lat);
    settle(10);
    chk("cont1_n", ord_q.size() - ob, 2);
    chk("cont1_first", ord_q[ob], 0);
    chk("cont1_second", ord_q[ob+1], 1);
    do_write(25'h210, 8'h23);
    settle(12);
    ob = ord_q.size();
    do_write(25'h220, 8'h24);
    do_read(25'h310, 8'h34, 60, 0, lat);
    settle(12);
    chk("cont2_n", ord_q.size() - ob, 2);
    chk("cont2_first", ord_q[ob], 1);
    chk("cont2_second", ord_q[ob+1], 0);
    chk("cont_count", bus.wr_count, 3);

    // Overflow: second strobe while holding full and ready stuck low.
    we0 = we_cnt;
    stuck = 1'b1; tick();
    do_write(25'h400, 8'h44);
    do_write(25'h401, 8'h55);
    tick();
    chk("ovf_set", bus.wr_ovf, 1);
    chk("ovf_busy", bus.wr_busy, 1);
    stuck = 1'b0;
    settle(12);
    chk("ovf_we_n", we_cnt - we0, 1);
    chk("ovf_we_addr", we_addr, 25'h400);
    chk("ovf_we_din", we_din, 8'h44);
    chk("ovf_count", bus.wr_count, 4);
    pulse_clr();
    chk("ovf_clr", bus.wr_ovf, 0);
    chk("ovf_clr_cnt", bus.wr_count, 0);

    // Strobe in the issuing cycle is accepted without overflow.
    we0 = we_cnt;
    stuck = 1'b1; tick();
    do_write(25'h500, 8'h66);
    settle(3);
    stuck = 1'b0;
    tick();
    chk("coinc_we", bus.mem_we, 1);
    do_write(25'h501, 8'h77);
    chk("coinc_no_ovf", bus.wr_ovf, 0);
    chk("coinc_busy", bus.wr_busy, 1);
    settle(15);
    chk("coinc_we_n", we_cnt - we0, 2);
    chk("coinc_we_addr", we_addr, 25'h501);
    chk("coinc_we_din", we_din, 8'h77);
    chk("coinc_count", bus.wr_count, 2);

    // Read timeout: ready held low after mem_rd.
    do_read(25'h800, 8'h12, 400, 1, lat);
    chk("tmo_latency", lat, 256);
    chk("tmo_data", ack_data, 8'hFF);
    chk("tmo_flag", bus.mem_tmo, 1);
    stuck = 1'b0;
    settle(6);
    chk("tmo_sticky", bus.mem_tmo, 1);
    chk("tmo_no_count", bus.wr_count, 2);
    pulse_clr();
    chk("tmo_clr", bus.mem_tmo, 0);
    do_read(25'h801, 8'h34, 50, 0, lat);
    chk("tmo_next_read", ack_data, 8'h34);
    settle(4);

    // Reset in the middle of a write WAIT.
    do_write(25'h600, 8'h80);
    settle(12);
    chk("pre_rst_count", bus.wr_count, 1);
    do_write(25'h610, 8'h88);
    wait_we("mid_we");
    stuck = 1'b1;
    settle(3);
    ack0 = ack_cnt;
    reset = 1'b1;
    settle(2);
    chk("mid_rst_count", bus.wr_count, 0);
    chk("mid_rst_misc", {bus.wr_busy, bus.wr_ovf, bus.rd_ack, bus.rd_data, bus.mem_din,
                         bus.mem_we, bus.mem_rd, bus.mem_tmo, bus.mem_addr}, 0);
    reset = 1'b0; stuck = 1'b0;
    we0 = we_cnt;
    settle(8);
    chk("mid_no_ack", ack_cnt - ack0, 0);
    chk("mid_no_we", we_cnt - we0, 0);
    chk("mid_still_zero", bus.wr_count, 0);
    do_write(25'h620, 8'h99);
    settle(12);
    chk("post_rst_count", bus.wr_count, 1);
    chk("post_rst_din", we_din, 8'h99);

    // cnt_clr in the completion cycle wins over the increment.
    do_write(25'h630, 8'hAA);
    wait_we("clr_we");
    settle(4);
    pulse_clr();
    chk("clr_prio", bus.wr_count, 0);
    settle(6);
    chk("clr_stays", bus.wr_count, 0);

    chk("never_both", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
